// File: rtl/ps2_tx_multi.sv
// rtl/ps2_tx_multi.sv - multi-channel PS/2 device transmitter with per-channel byte FIFOs
// One shared PS/2 clock divider; each channel frames bytes from its own FIFO.
module ps2_tx_multi #(
    parameter int CHANNELS  = 2,
    parameter int FIFO_BITS = 3,
    parameter int PS2DIV    = 100
) (
    input  logic                clk_sys,
    input  logic                reset,
    input  logic [CHANNELS-1:0] wr,
    input  logic [7:0]          wr_data,
    input  logic [CHANNELS-1:0] ps2_clk_in,
    input  logic [CHANNELS-1:0] ovf_clr,
    output logic [CHANNELS-1:0] ps2_clk,
    output logic [CHANNELS-1:0] ps2_data,
    output logic [CHANNELS-1:0] fifo_empty,
    output logic [CHANNELS-1:0] fifo_full,
    output logic [CHANNELS-1:0] overflow,
    output logic [CHANNELS-1:0] busy
);

    localparam int CNT_W = (PS2DIV < 1) ? 1 : $clog2(PS2DIV + 1);
    localparam int PTR_W = FIFO_BITS + 1;
    localparam int DEPTH = 1 << FIFO_BITS;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_D1     = 4'd1,
        ST_D2     = 4'd2,
        ST_D3     = 4'd3,
        ST_D4     = 4'd4,
        ST_D5     = 4'd5,
        ST_D6     = 4'd6,
        ST_D7     = 4'd7,
        ST_D8     = 4'd8,
        ST_PARITY = 4'd9,
        ST_STOP   = 4'd10,
        ST_END    = 4'd11
    } tx_state_t;

    logic [CNT_W-1:0] cnt;
    logic             clk_ps2;
    logic             wrap;
    logic             rise_tick;
    logic             fall_tick;

    assign wrap      = (cnt == CNT_W'(PS2DIV));
    assign rise_tick = wrap && !clk_ps2;
    assign fall_tick = wrap && clk_ps2;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            clk_ps2 <= 1'b0;
        end else if (wrap) begin
            cnt     <= '0;
            clk_ps2 <= ~clk_ps2;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [7:0]       mem [DEPTH];
        logic [PTR_W-1:0] wptr;
        logic [PTR_W-1:0] rptr;
        logic             empty;
        logic             full;
        logic             push;
        logic             start;
        logic             pop;
        logic             sync1;
        logic             sync2;
        logic             inhibit;
        logic             retry;
        logic             parity;
        logic             data_q;
        logic             ovf_q;
        logic [7:0]       tx_byte;
        logic [7:0]       shreg;
        tx_state_t        tx_state;

        assign empty = (wptr == rptr);
        assign full  = (wptr[FIFO_BITS] != rptr[FIFO_BITS]) &&
                       (wptr[FIFO_BITS-1:0] == rptr[FIFO_BITS-1:0]);
        // A full FIFO drops the push even if the same cycle pops.
        assign push  = wr[i] && !full;
        assign start = rise_tick && (tx_state == ST_IDLE) && !inhibit && (!empty || retry);
        assign pop   = start && !retry;

        always_ff @(posedge clk_sys) begin
            if (push) begin
                mem[wptr[FIFO_BITS-1:0]] <= wr_data;
            end
        end

        always_ff @(posedge clk_sys or posedge reset) begin
            if (reset) begin
                wptr    <= '0;
                rptr    <= '0;
                ovf_q   <= 1'b0;
                sync1   <= 1'b1;
                sync2   <= 1'b1;
                inhibit <= 1'b0;
            end else begin
                sync1 <= ps2_clk_in[i];
                sync2 <= sync1;
                if (fall_tick) begin
                    inhibit <= ~sync2;
                end
                if (push) begin
                    wptr <= wptr + PTR_W'(1);
                end
                if (pop) begin
                    rptr <= rptr + PTR_W'(1);
                end
                if (wr[i] && full) begin
                    ovf_q <= 1'b1;
                end else if (ovf_clr[i]) begin
                    ovf_q <= 1'b0;
                end
            end
        end

        always_ff @(posedge clk_sys or posedge reset) begin
            if (reset) begin
                tx_state <= ST_IDLE;
                retry    <= 1'b0;
                parity   <= 1'b1;
                data_q   <= 1'b1;
                tx_byte  <= '0;
                shreg    <= '0;
            end else if (rise_tick) begin
                case (tx_state)
                    ST_IDLE: begin
                        if (start) begin
                            data_q   <= 1'b0;
                            parity   <= 1'b1;
                            tx_state <= ST_D1;
                            if (retry) begin
                                shreg <= tx_byte;
                            end else begin
                                tx_byte <= mem[rptr[FIFO_BITS-1:0]];
                                shreg   <= mem[rptr[FIFO_BITS-1:0]];
                            end
                        end
                    end
                    ST_PARITY: begin
                        if (inhibit) begin
                            tx_state <= ST_IDLE;
                            data_q   <= 1'b1;
                            retry    <= 1'b1;
                        end else begin
                            data_q   <= parity;
                            tx_state <= ST_STOP;
                        end
                    end
                    ST_STOP: begin
                        data_q   <= 1'b1;
                        tx_state <= ST_END;
                    end
                    ST_END: begin
                        retry    <= 1'b0;
                        tx_state <= ST_IDLE;
                    end
                    default: begin
                        // Host inhibit before the parity bit aborts; tx_byte is kept for the resend.
                        if (inhibit) begin
                            tx_state <= ST_IDLE;
                            data_q   <= 1'b1;
                            retry    <= 1'b1;
                        end else begin
                            data_q   <= shreg[0];
                            parity   <= parity ^ shreg[0];
                            shreg    <= {1'b0, shreg[7:1]};
                            tx_state <= tx_state_t'(tx_state + 4'd1);
                        end
                    end
                endcase
            end
        end

        assign ps2_clk[i]    = clk_ps2 | (tx_state == ST_IDLE);
        assign ps2_data[i]   = data_q;
        assign fifo_empty[i] = empty;
        assign fifo_full[i]  = full;
        assign overflow[i]   = ovf_q;
        assign busy[i]       = (tx_state != ST_IDLE);
    end

endmodule

// File: tb/tb_ps2_tx_multi.sv
// tb/tb_ps2_tx_multi.sv - self-checking bench for ps2_tx_multi
// Frames are decoded from ps2_clk falling edges and compared with byte queues.
module tb_ps2_tx_multi;

    localparam int CH  = 2;
    localparam int FB  = 3;
    localparam int DIV = 2;

    logic          clk_sys = 1'b0;
    logic          reset   = 1'b1;
    logic [CH-1:0] wr      = '0;
    logic [7:0]    wr_data = '0;
    logic [CH-1:0] ps2_clk_in = '1;
    logic [CH-1:0] ovf_clr = '0;
    logic [CH-1:0] ps2_clk;
    logic [CH-1:0] ps2_data;
    logic [CH-1:0] fifo_empty;
    logic [CH-1:0] fifo_full;
    logic [CH-1:0] overflow;
    logic [CH-1:0] busy;

    int checks   = 0;
    int failures = 0;

    ps2_tx_multi #(.CHANNELS(CH), .FIFO_BITS(FB), .PS2DIV(DIV)) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .wr         (wr),
        .wr_data    (wr_data),
        .ps2_clk_in (ps2_clk_in),
        .ovf_clr    (ovf_clr),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .fifo_empty (fifo_empty),
        .fifo_full  (fifo_full),
        .overflow   (overflow),
        .busy       (busy)
    );

    always #5 clk_sys = ~clk_sys;

    // Line order: start, data LSB first, odd parity, stop.
    function automatic logic [10:0] frame_of(input logic [7:0] b);
        return {1'b1, ~(^b), b, 1'b0};
    endfunction

    task automatic push(input logic [CH-1:0] mask, input logic [7:0] b);
        @(negedge clk_sys);
        wr      = mask;
        wr_data = b;
        @(negedge clk_sys);
        wr = '0;
    endtask

    task automatic get_frame(input int ch, output logic [10:0] bits, output bit ok,
                             output bit other_low);
        int   n;
        int   t;
        logic prev;
        n = 0;
        t = 0;
        bits = '0;
        ok = 1'b1;
        other_low = 1'b0;
        prev = ps2_clk[ch];
        while (n < 11) begin
            @(negedge clk_sys);
            t++;
            if (ps2_clk[1-ch] !== 1'b1) other_low = 1'b1;
            if (prev === 1'b1 && ps2_clk[ch] === 1'b0) begin
                bits[n] = ps2_data[ch];
                n++;
            end
            prev = ps2_clk[ch];
            if (t > 600) begin
                ok = 1'b0;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int ch);
        int t;
        t = 0;
        while (busy[ch] !== 1'b0 && t < 100) begin
            @(negedge clk_sys);
            t++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk_sys);
        checks++; if (ps2_data !== 2'b11) begin failures++; $display("FAIL rst_data: got %b expected 11", ps2_data); end
        checks++; if (ps2_clk !== 2'b11) begin failures++; $display("FAIL rst_clk: got %b expected 11", ps2_clk); end
        checks++; if (fifo_empty !== 2'b11) begin failures++; $display("FAIL rst_empty: got %b expected 11", fifo_empty); end
        checks++; if (fifo_full !== 2'b00) begin failures++; $display("FAIL rst_full: got %b expected 00", fifo_full); end
        checks++; if (overflow !== 2'b00) begin failures++; $display("FAIL rst_ovf: got %b expected 00", overflow); end
        checks++; if (busy !== 2'b00) begin failures++; $display("FAIL rst_busy: got %b expected 00", busy); end
        reset = 1'b0;
        repeat (2) @(negedge clk_sys);
    endtask

    task automatic test_frame_a5;
        logic [10:0] bits;
        bit ok, ol;
        push(2'b01, 8'hA5);
        get_frame(0, bits, ok, ol);
        checks++; if (!ok) begin failures++; $display("FAIL a5_timeout: got no frame expected 11 bits"); end
        checks++; if (bits !== 11'b11101001010) begin failures++; $display("FAIL a5_frame: got %b expected %b", bits, 11'b11101001010); end
        wait_idle(0);
        checks++; if (busy[0] !== 1'b0) begin failures++; $display("FAIL a5_busy: got %b expected 0", busy[0]); end
        checks++; if (fifo_empty[0] !== 1'b1) begin failures++; $display("FAIL a5_empty: got %b expected 1", fifo_empty[0]); end
    endtask

    task automatic test_overflow;
        logic [7:0] q[$];
        logic [7:0] b;
        logic [10:0] bits;
        bit ok, ol;
        ps2_clk_in[0] = 1'b0;
        repeat (20) @(negedge clk_sys);
        for (int i = 0; i < 9; i++) begin
            b = 8'($urandom);
            push(2'b01, b);
            if (i < 8) q.push_back(b);
            checks++; if (fifo_full[0] !== (i >= 7)) begin failures++; $display("FAIL ovf_full%0d: got %b expected %b", i, fifo_full[0], (i >= 7)); end
            checks++; if (overflow[0] !== (i == 8)) begin failures++; $display("FAIL ovf_flag%0d: got %b expected %b", i, overflow[0], (i == 8)); end
        end
        checks++; if (busy[0] !== 1'b0) begin failures++; $display("FAIL ovf_inhibit_busy: got %b expected 0", busy[0]); end
        @(negedge clk_sys);
        wr[0] = 1'b1; ovf_clr[0] = 1'b1;
        @(negedge clk_sys);
        wr[0] = 1'b0; ovf_clr[0] = 1'b0;
        checks++; if (overflow[0] !== 1'b1) begin failures++; $display("FAIL ovf_drop_wins: got %b expected 1", overflow[0]); end
        @(negedge clk_sys);
        ovf_clr[0] = 1'b1;
        @(negedge clk_sys);
        ovf_clr[0] = 1'b0;
        checks++; if (overflow[0] !== 1'b0) begin failures++; $display("FAIL ovf_clr: got %b expected 0", overflow[0]); end
        ps2_clk_in[0] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            get_frame(0, bits, ok, ol);
            checks++; if (!ok || bits !== frame_of(q[k])) begin failures++; $display("FAIL drain%0d: got %b expected %b", k, bits, frame_of(q[k])); end
        end
        wait_idle(0);
        checks++; if (fifo_empty[0] !== 1'b1) begin failures++; $display("FAIL drain_empty: got %b expected 1", fifo_empty[0]); end
    endtask

    task automatic test_ch1_parity;
        logic [10:0] bits;
        bit ok, ol;
        logic [7:0] seq [2];
        seq[0] = 8'h00;
        seq[1] = 8'hFF;
        push(2'b10, seq[0]);
        push(2'b10, seq[1]);
        for (int k = 0; k < 2; k++) begin
            get_frame(1, bits, ok, ol);
            checks++; if (!ok || bits !== frame_of(seq[k])) begin failures++; $display("FAIL ch1_frame%0d: got %b expected %b", k, bits, frame_of(seq[k])); end
            checks++; if (bits[9] !== 1'b1) begin failures++; $display("FAIL ch1_parity%0d: got %b expected 1", k, bits[9]); end
            checks++; if (ol) begin failures++; $display("FAIL ch0_idle_clk%0d: got low expected 1", k); end
        end
        wait_idle(1);
    endtask

    task automatic test_retry;
        logic [7:0] b2;
        logic [10:0] bits;
        bit ok, ol;
        int nf, t;
        bit any_busy;
        logic prev;
        b2 = 8'($urandom);
        ps2_clk_in[0] = 1'b0;
        repeat (20) @(negedge clk_sys);
        push(2'b01, 8'h3C);
        push(2'b01, b2);
        ps2_clk_in[0] = 1'b1;
        nf = 0; t = 0; prev = ps2_clk[0];
        while (nf < 5 && t < 300) begin
            @(negedge clk_sys); t++;
            if (prev === 1'b1 && ps2_clk[0] === 1'b0) nf++;
            prev = ps2_clk[0];
        end
        ps2_clk_in[0] = 1'b0;
        t = 0;
        while (busy[0] !== 1'b0 && t < 100) begin
            @(negedge clk_sys); t++;
            if (prev === 1'b1 && ps2_clk[0] === 1'b0) nf++;
            prev = ps2_clk[0];
        end
        checks++; if (busy[0] !== 1'b0 || nf >= 11) begin failures++; $display("FAIL retry_abort: got busy=%b falls=%0d expected busy=0 falls<11", busy[0], nf); end
        checks++; if (ps2_data[0] !== 1'b1) begin failures++; $display("FAIL retry_data: got %b expected 1", ps2_data[0]); end
        checks++; if (ps2_clk[0] !== 1'b1) begin failures++; $display("FAIL retry_clk: got %b expected 1", ps2_clk[0]); end
        checks++; if (fifo_empty[0] !== 1'b0) begin failures++; $display("FAIL retry_nopop: got %b expected 0", fifo_empty[0]); end
        any_busy = 1'b0;
        repeat (60) begin
            @(negedge clk_sys);
            if (busy[0] !== 1'b0) any_busy = 1'b1;
        end
        checks++; if (any_busy) begin failures++; $display("FAIL retry_hold: got busy expected idle while inhibited"); end
        ps2_clk_in[0] = 1'b1;
        get_frame(0, bits, ok, ol);
        checks++; if (!ok || bits !== frame_of(8'h3C)) begin failures++; $display("FAIL retry_resend: got %b expected %b", bits, frame_of(8'h3C)); end
        get_frame(0, bits, ok, ol);
        checks++; if (!ok || bits !== frame_of(b2)) begin failures++; $display("FAIL retry_next: got %b expected %b", bits, frame_of(b2)); end
        wait_idle(0);
        checks++; if (fifo_empty[0] !== 1'b1) begin failures++; $display("FAIL retry_empty: got %b expected 1", fifo_empty[0]); end
    endtask

    task automatic test_stop_inhibit;
        logic [7:0] b;
        logic [10:0] bits;
        int nf, t;
        bit pulled, any_busy;
        logic prev;
        b = 8'($urandom);
        push(2'b01, b);
        nf = 0; t = 0; pulled = 1'b0; bits = '0; prev = ps2_clk[0];
        while (nf < 11 && t < 400) begin
            @(negedge clk_sys); t++;
            if (prev === 1'b1 && ps2_clk[0] === 1'b0) begin
                bits[nf] = ps2_data[0];
                nf++;
            end
            if (nf == 10 && !pulled && prev === 1'b0 && ps2_clk[0] === 1'b1) begin
                ps2_clk_in[0] = 1'b0;
                pulled = 1'b1;
            end
            prev = ps2_clk[0];
        end
        checks++; if (nf != 11 || bits !== frame_of(b)) begin failures++; $display("FAIL stop_frame: got %b expected %b", bits, frame_of(b)); end
        wait_idle(0);
        checks++; if (busy[0] !== 1'b0) begin failures++; $display("FAIL stop_busy: got %b expected 0", busy[0]); end
        repeat (30) @(negedge clk_sys);
        ps2_clk_in[0] = 1'b1;
        any_busy = 1'b0;
        repeat (80) begin
            @(negedge clk_sys);
            if (busy[0] !== 1'b0) any_busy = 1'b1;
        end
        checks++; if (any_busy) begin failures++; $display("FAIL stop_no_resend: got resend expected idle"); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] q0[$];
        logic [7:0] q1[$];
        logic [7:0] b;
        int r;
        ps2_clk_in = 2'b00;
        repeat (20) @(negedge clk_sys);
        for (int k = 0; k < 6; k++) begin
            b = 8'($urandom);
            r = int'($urandom_range(0, 2));
            if (r == 0) begin push(2'b01, b); q0.push_back(b); end
            else if (r == 1) begin push(2'b10, b); q1.push_back(b); end
            else begin push(2'b11, b); q0.push_back(b); q1.push_back(b); end
        end
        ps2_clk_in = 2'b11;
        fork
            begin
                logic [10:0] bits0;
                bit ok0, ol0;
                for (int k = 0; k < q0.size(); k++) begin
                    get_frame(0, bits0, ok0, ol0);
                    checks++; if (!ok0 || bits0 !== frame_of(q0[k])) begin failures++; $display("FAIL b2b_ch0_%0d: got %b expected %b", k, bits0, frame_of(q0[k])); end
                end
            end
            begin
                logic [10:0] bits1;
                bit ok1, ol1;
                for (int k = 0; k < q1.size(); k++) begin
                    get_frame(1, bits1, ok1, ol1);
                    checks++; if (!ok1 || bits1 !== frame_of(q1[k])) begin failures++; $display("FAIL b2b_ch1_%0d: got %b expected %b", k, bits1, frame_of(q1[k])); end
                end
            end
        join
        wait_idle(0);
        wait_idle(1);
        checks++; if (fifo_empty !== 2'b11) begin failures++; $display("FAIL b2b_empty: got %b expected 11", fifo_empty); end
    endtask

    task automatic test_reset_mid_frame;
        int nf, t;
        bit seen_rise, any_busy;
        logic prev;
        ps2_clk_in = 2'b00;
        repeat (20) @(negedge clk_sys);
        for (int k = 0; k < 4; k++) push(2'b01, 8'($urandom));
        push(2'b10, 8'($urandom));
        ps2_clk_in = 2'b11;
        nf = 0; t = 0; seen_rise = 1'b0; prev = ps2_clk[0];
        while (!seen_rise && t < 400) begin
            @(negedge clk_sys); t++;
            if (prev === 1'b1 && ps2_clk[0] === 1'b0) nf++;
            if (nf == 4 && prev === 1'b0 && ps2_clk[0] === 1'b1) seen_rise = 1'b1;
            prev = ps2_clk[0];
        end
        checks++; if (!seen_rise || busy[0] !== 1'b1) begin failures++; $display("FAIL mid_reach: got busy=%b expected 1 at bit 5", busy[0]); end
        reset = 1'b1;
        @(negedge clk_sys);
        checks++; if (busy !== 2'b00) begin failures++; $display("FAIL mid_busy: got %b expected 00", busy); end
        checks++; if (fifo_empty !== 2'b11) begin failures++; $display("FAIL mid_empty: got %b expected 11", fifo_empty); end
        checks++; if (ps2_data !== 2'b11) begin failures++; $display("FAIL mid_data: got %b expected 11", ps2_data); end
        checks++; if (ps2_clk !== 2'b11) begin failures++; $display("FAIL mid_clk: got %b expected 11", ps2_clk); end
        reset = 1'b0;
        any_busy = 1'b0;
        repeat (100) begin
            @(negedge clk_sys);
            if (busy !== 2'b00) any_busy = 1'b1;
        end
        checks++; if (any_busy) begin failures++; $display("FAIL mid_discard: got activity expected idle after reset"); end
    endtask

    initial begin
        test_reset();
        test_frame_a5();
        test_overflow();
        test_ch1_parity();
        test_retry();
        test_stop_inhibit();
        test_back_to_back();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
